xmuladd_sched: RTL and testbench

Job scheduler that time-shares one `xmuladd` instance among `N_REQ` requesters. Each requester presents a full muladd configuration word. The scheduler arbitrates round-robin, loads the winner's configuration, and pulses the muladd start/init strobe. It counts the job's run length, captures `flow_out` when the job completes, and returns the result tagged with the requester id. It sits between the engine control logic and the shared muladd datapath.

---
 rtl/xmuladd_sched_pkg.sv | 48 ++++
 rtl/xmuladd_sched_xrr_arbiter.sv | 35 +++
 rtl/xmuladd_sched.sv | 150 +++++++++++++++
 tb/tb_xmuladd_sched.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/xmuladd_sched_pkg.sv
// Shared definitions for the muladd job scheduler: configdata field layout,
// run-length width, scheduler state encoding and field-extraction helpers.
package xmuladd_sched_pkg;

  localparam int MEM_ADDR_W       = 8;
  localparam int PERIOD_W         = 4;
  localparam int DELAY_W          = 4;

  localparam int ITER_OFF         = 0;
  localparam int PERIOD_OFF       = ITER_OFF + MEM_ADDR_W;
  localparam int DELAY_OFF        = PERIOD_OFF + PERIOD_W;
  localparam int MULADD_CONF_BITS = DELAY_OFF + DELAY_W;

  // Wide enough for delay + iterations*period + pipeline latency.
  localparam int RUNLEN_W         = MEM_ADDR_W + PERIOD_W + 1;

  typedef enum logic [1:0] {
    MSCHED_IDLE = 2'd0,
    MSCHED_LOAD = 2'd1,
    MSCHED_RUN  = 2'd2,
    MSCHED_RESP = 2'd3
  } msched_state_e;

  function automatic logic [MEM_ADDR_W-1:0] conf_iters(input logic [MULADD_CONF_BITS-1:0] conf);
    return conf[ITER_OFF +: MEM_ADDR_W];
  endfunction

  function automatic logic [PERIOD_W-1:0] conf_period(input logic [MULADD_CONF_BITS-1:0] conf);
    return conf[PERIOD_OFF +: PERIOD_W];
  endfunction

  function automatic logic [DELAY_W-1:0] conf_delay(input logic [MULADD_CONF_BITS-1:0] conf);
    return conf[DELAY_OFF +: DELAY_W];
  endfunction

  // Cycles the muladd needs before flow_out holds the finished result.
  function automatic logic [RUNLEN_W-1:0] conf_run_len(input logic [MULADD_CONF_BITS-1:0] conf,
                                                      input logic [RUNLEN_W-1:0]         pipe_lat);
    logic [RUNLEN_W-1:0] iters;
    logic [RUNLEN_W-1:0] period;
    logic [RUNLEN_W-1:0] delay;
    iters  = RUNLEN_W'(conf_iters(conf));
    period = RUNLEN_W'(conf_period(conf));
    delay  = RUNLEN_W'(conf_delay(conf));
    return delay + iters * period + pipe_lat;
  endfunction

endpackage

// File: rtl/xmuladd_sched_xrr_arbiter.sv
// Combinational round-robin picker: the search starts one past the last
// granted index and wraps, so every active requester is served in turn.
module xrr_arbiter #(
  parameter  int N    = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] last_i,
  output logic [N-1:0]    grant_o,
  output logic            valid_o,
  output logic [ID_W-1:0] id_o
);

  // Walk the requesters in rotating priority order and take the first one.
  always_comb begin
    int             pos;
    logic [ID_W-1:0] idx;
    logic           found;
    grant_o = '0;
    id_o    = '0;
    found   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      pos = int'(last_i) + k;
      if (pos >= N) pos = pos - N;
      idx = ID_W'(pos);
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        id_o         = idx;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/xmuladd_sched.sv
// Time-shares one muladd among N_REQ requesters: round-robin grant, config
// load with a start strobe, run-length countdown, tagged result capture.
module xmuladd_sched
  import xmuladd_sched_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int DATA_W   = 32,
  parameter  int PIPE_LAT = 4,
  localparam int ID_W     = $clog2(N_REQ)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_REQ-1:0]                  req_valid_i,
  input  logic [N_REQ*MULADD_CONF_BITS-1:0] req_conf_i,
  output logic [N_REQ-1:0]                  req_ready_o,
  input  logic                              abort_i,
  output logic [MULADD_CONF_BITS-1:0]       mul_conf_o,
  output logic                              mul_start_o,
  input  logic [DATA_W-1:0]                 mul_out_i,
  output logic                              res_valid_o,
  input  logic                              res_ready_i,
  output logic [ID_W-1:0]                   res_id_o,
  output logic [DATA_W-1:0]                 res_data_o,
  output logic                              res_err_o,
  output logic                              busy_o
);

  msched_state_e               state_q, state_d;
  logic [ID_W-1:0]             last_q, last_d;
  logic [ID_W-1:0]             job_id_q, job_id_d;
  logic [MULADD_CONF_BITS-1:0] conf_q, conf_d;
  logic                        start_q, start_d;
  logic [RUNLEN_W-1:0]         cnt_q, cnt_d;
  logic [ID_W-1:0]             res_id_q, res_id_d;
  logic [DATA_W-1:0]           res_data_q, res_data_d;
  logic                        res_err_q, res_err_d;

  logic [N_REQ-1:0]            grant;
  logic                        grant_valid;
  logic [ID_W-1:0]             grant_id;
  logic [MULADD_CONF_BITS-1:0] conf_sel;
  logic [RUNLEN_W-1:0]         run_len;

  xrr_arbiter #(.N(N_REQ)) u_arb (
    .req_i   (req_valid_i),
    .last_i  (last_q),
    .grant_o (grant),
    .valid_o (grant_valid),
    .id_o    (grant_id)
  );

  // Pick the winning requester's configuration word out of the packed bus.
  always_comb begin
    conf_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == ID_W'(i)) conf_sel = req_conf_i[i*MULADD_CONF_BITS +: MULADD_CONF_BITS];
    end
  end

  assign run_len = conf_run_len(conf_q, RUNLEN_W'(PIPE_LAT));

  // Next-state logic; the LOAD cycle already counts as the first cycle of the
  // run window, so the counter starts at L-1 and the capture lands on cycle L.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    job_id_d   = job_id_q;
    conf_d     = conf_q;
    start_d    = 1'b0;
    cnt_d      = cnt_q;
    res_id_d   = res_id_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    case (state_q)
      MSCHED_IDLE: begin
        if (grant_valid) begin
          conf_d   = conf_sel;
          job_id_d = grant_id;
          last_d   = grant_id;
          start_d  = 1'b1;
          state_d  = MSCHED_LOAD;
        end
      end
      MSCHED_LOAD: begin
        if (abort_i) begin
          state_d = MSCHED_IDLE;
        end else if (conf_iters(conf_q) == '0) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
          res_id_d   = job_id_q;
          state_d    = MSCHED_RESP;
        end else begin
          cnt_d   = run_len - RUNLEN_W'(1);
          state_d = MSCHED_RUN;
        end
      end
      MSCHED_RUN: begin
        if (abort_i) begin
          state_d = MSCHED_IDLE;
        end else if (cnt_q == RUNLEN_W'(1)) begin
          res_data_d = mul_out_i;
          res_err_d  = 1'b0;
          res_id_d   = job_id_q;
          state_d    = MSCHED_RESP;
        end else begin
          cnt_d = cnt_q - RUNLEN_W'(1);
        end
      end
      MSCHED_RESP: begin
        if (res_ready_i) state_d = MSCHED_IDLE;
      end
      default: state_d = MSCHED_IDLE;
    endcase
  end

  // State and datapath registers; last grant resets so requester 0 goes first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= MSCHED_IDLE;
      last_q     <= ID_W'(N_REQ - 1);
      job_id_q   <= '0;
      conf_q     <= '0;
      start_q    <= 1'b0;
      cnt_q      <= '0;
      res_id_q   <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      job_id_q   <= job_id_d;
      conf_q     <= conf_d;
      start_q    <= start_d;
      cnt_q      <= cnt_d;
      res_id_q   <= res_id_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

  assign req_ready_o = (state_q == MSCHED_IDLE) ? grant : '0;
  assign mul_conf_o  = conf_q;
  assign mul_start_o = start_q;
  assign res_valid_o = (state_q == MSCHED_RESP);
  assign res_id_o    = res_id_q;
  assign res_data_o  = res_data_q;
  assign res_err_o   = res_err_q;
  assign busy_o      = (state_q != MSCHED_IDLE);

endmodule

// File: tb/tb_xmuladd_sched.sv
// Self-checking bench for xmuladd_sched: directed scenarios plus random jobs
// against a cycle-level job model (round-robin pick, run-length arithmetic).
module tb_xmuladd_sched;
  import xmuladd_sched_pkg::*;

  localparam int N_REQ    = 4;
  localparam int DATA_W   = 32;
  localparam int PIPE_LAT = 4;
  localparam int CONF_W   = MULADD_CONF_BITS;
  localparam int ID_W     = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [N_REQ-1:0]        req_valid_i = '0;
  logic [N_REQ*CONF_W-1:0] req_conf_i = '0;
  logic [N_REQ-1:0]        req_ready_o;
  logic                    abort_i = 1'b0;
  logic [CONF_W-1:0]       mul_conf_o;
  logic                    mul_start_o;
  logic [DATA_W-1:0]       mul_out_i = '0;
  logic                    res_valid_o;
  logic                    res_ready_i = 1'b0;
  logic [ID_W-1:0]         res_id_o;
  logic [DATA_W-1:0]       res_data_o;
  logic                    res_err_o;
  logic                    busy_o;

  int                      nChecks = 0;
  int                      nFails = 0;
  int                      modelLast = N_REQ - 1;
  logic [N_REQ-1:0]        lastReady;
  logic [DATA_W-1:0]       mulOut [0:511];
  logic [N_REQ*CONF_W-1:0] cf;

  xmuladd_sched #(.N_REQ(N_REQ), .DATA_W(DATA_W), .PIPE_LAT(PIPE_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_conf_i  (req_conf_i),
    .req_ready_o (req_ready_o),
    .abort_i     (abort_i),
    .mul_conf_o  (mul_conf_o),
    .mul_start_o (mul_start_o),
    .mul_out_i   (mul_out_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_id_o    (res_id_o),
    .res_data_o  (res_data_o),
    .res_err_o   (res_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  // Watchdog so a wedged run still ends with a visible report.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [CONF_W-1:0] mkConf(input int iters, input int period, input int delay);
    logic [CONF_W-1:0] c;
    c = '0;
    c[ITER_OFF +: MEM_ADDR_W] = MEM_ADDR_W'(iters);
    c[PERIOD_OFF +: PERIOD_W] = PERIOD_W'(period);
    c[DELAY_OFF +: DELAY_W]   = DELAY_W'(delay);
    return c;
  endfunction

  function automatic logic [N_REQ*CONF_W-1:0] randConfs();
    logic [N_REQ*CONF_W-1:0] v;
    for (int i = 0; i < N_REQ; i++)
      v[i*CONF_W +: CONF_W] = mkConf($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 7));
    return v;
  endfunction

  function automatic int rrPick(input int last, input logic [N_REQ-1:0] mask);
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (last + k) % N_REQ;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  // One job from its IDLE grant cycle through handshake or abort.
  // abortAt: -1 none, -2 random cycle inside LOAD/RUN, otherwise that cycle.
  task automatic applyStimulus(input logic [N_REQ-1:0] mask, input logic [N_REQ*CONF_W-1:0] confs,
                               input int bp, input int abortAt);
    int win, iters, period, delay, runLen, respAt, abortCyc, c;
    logic [CONF_W-1:0] wc;
    bit done;
    @(negedge clk);
    req_valid_i = mask;
    req_conf_i  = confs;
    abort_i     = 1'b0;
    res_ready_i = 1'b0;
    mul_out_i   = $urandom;
    #1;
    win = rrPick(modelLast, mask);
    lastReady = req_ready_o;
    checkOutput("busy_idle", busy_o, 0);
    checkOutput("res_valid_idle", res_valid_o, 0);
    checkOutput("grant", req_ready_o, (win < 0) ? 0 : (1 << win));
    if (win < 0) return;
    modelLast = win;
    wc     = confs[win*CONF_W +: CONF_W];
    iters  = int'(wc[ITER_OFF +: MEM_ADDR_W]);
    period = int'(wc[PERIOD_OFF +: PERIOD_W]);
    delay  = int'(wc[DELAY_OFF +: DELAY_W]);
    runLen = delay + iters * period + PIPE_LAT;
    respAt = (iters == 0) ? 2 : 1 + runLen;
    abortCyc = (abortAt == -2) ? $urandom_range(1, respAt - 1) : abortAt;
    done = 1'b0;
    c = 0;
    while (!done) begin
      @(negedge clk);
      c++;
      mulOut[c]   = $urandom;
      mul_out_i   = mulOut[c];
      abort_i     = (c == abortCyc);
      res_ready_i = (c >= respAt + bp);
      #1;
      checkOutput("req_ready_busy", req_ready_o, 0);
      checkOutput("busy", busy_o, 1);
      checkOutput("mul_start", mul_start_o, c == 1);
      checkOutput("mul_conf", mul_conf_o, wc);
      checkOutput("res_valid", res_valid_o, c >= respAt);
      if (c >= respAt) begin
        checkOutput("res_id", res_id_o, win);
        checkOutput("res_data", res_data_o, (iters == 0) ? 0 : mulOut[runLen]);
        checkOutput("res_err", res_err_o, iters == 0);
      end
      if (c == abortCyc || c >= respAt + bp || c >= 500) done = 1'b1;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_req_ready", req_ready_o, 0);
    checkOutput("rst_mul_conf", mul_conf_o, 0);
    checkOutput("rst_mul_start", mul_start_o, 0);
    checkOutput("rst_res_valid", res_valid_o, 0);
    checkOutput("rst_res_id", res_id_o, 0);
    checkOutput("rst_res_data", res_data_o, 0);
    checkOutput("rst_res_err", res_err_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    rst = 1'b0;

    // Fairness from reset: 0,1,2,3,0 with everybody requesting.
    for (int j = 0; j < 5; j++) begin
      applyStimulus(4'hF, randConfs(), 0, -1);
      checkOutput("fair_order", lastReady, 4'b0001 << (j % 4));
    end

    // Single job on requester 2: iterations 4, period 1, delay 0 -> L = 8.
    cf = randConfs();
    cf[2*CONF_W +: CONF_W] = mkConf(4, 1, 0);
    applyStimulus(4'b0100, cf, 0, -1);

    // Zero-iteration job returns an error result two cycles after accept.
    cf = randConfs();
    cf[1*CONF_W +: CONF_W] = mkConf(0, 2, 3);
    applyStimulus(4'b0010, cf, 0, -1);

    // Backpressure: consumer stalls for 20 cycles with others still requesting.
    cf = randConfs();
    cf[3*CONF_W +: CONF_W] = mkConf(3, 2, 1);
    applyStimulus(4'b1111, cf, 20, -1);

    // Abort three cycles into RUN, then the next requester in line wins.
    cf = randConfs();
    cf[0*CONF_W +: CONF_W] = mkConf(6, 2, 1);
    applyStimulus(4'b0001, cf, 0, 5);
    applyStimulus(4'hF, randConfs(), 0, -1);
    checkOutput("after_abort_grant", lastReady, 4'b0010);

    // Random mix of masks, configs, stalls and aborts.
    for (int j = 0; j < 40; j++) begin
      applyStimulus(4'($urandom_range(1, 15)), randConfs(), $urandom_range(0, 3),
                    ($urandom_range(0, 9) == 0) ? -2 : -1);
    end

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    cf = randConfs();
    cf[2*CONF_W +: CONF_W] = mkConf(6, 3, 2);
    req_valid_i = 4'b0100;
    req_conf_i  = cf;
    abort_i     = 1'b0;
    res_ready_i = 1'b1;
    repeat (5) @(negedge clk);
    req_valid_i = '0;
    #1;
    checkOutput("busy_before_reset", busy_o, 1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_req_ready", req_ready_o, 0);
    checkOutput("midrst_mul_conf", mul_conf_o, 0);
    checkOutput("midrst_mul_start", mul_start_o, 0);
    checkOutput("midrst_res_valid", res_valid_o, 0);
    checkOutput("midrst_res_id", res_id_o, 0);
    checkOutput("midrst_res_data", res_data_o, 0);
    checkOutput("midrst_res_err", res_err_o, 0);
    checkOutput("midrst_busy", busy_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelLast = N_REQ - 1;
    @(negedge clk);
    #1;
    checkOutput("no_restart", mul_start_o, 0);
    checkOutput("idle_after_reset", busy_o, 0);
    applyStimulus(4'hF, randConfs(), 0, -1);
    checkOutput("first_after_reset", lastReady, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
    $finish;
  end

endmodule
